stage_mem_lsu: RTL and testbench

- Parametrised load/store unit replacing the byte-serial MEM-stage memory sequencer.
- Sits between the EX/MEM pipeline register and the external RAM port, with an optional data-cache port.
- Splits LB/LBU/LH/LHU/LW/SB/SH/SW accesses into MEM_BYTES-wide beats and issues those beats back-to-back, one per cycle.
- Assembles and extends load data; returns one registered response per request.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_load_align.sv | 35 +++
 rtl/stage_mem_lsu.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_stage_mem_lsu.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the MEM-stage load/store unit:
//               access-size encodings, FSM state encoding and the
//               bytes/beats-per-access helpers derived from the RAM bus width.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Access size encodings as presented on req_size_i (3 is folded to word).
  localparam logic [1:0] LSU_SZ_B = 2'd0;
  localparam logic [1:0] LSU_SZ_H = 2'd1;
  localparam logic [1:0] LSU_SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Number of bytes touched by an access of the given size.
  function automatic int lsu_bytes(input logic [1:0] size);
    case (size)
      LSU_SZ_B: return 1;
      LSU_SZ_H: return 2;
      default:  return 4;
    endcase
  endfunction

  // Beats needed on a mem_bytes-wide bus: ceil(bytes / mem_bytes).
  function automatic logic [2:0] lsu_beats(input logic [1:0] size, input int mem_bytes);
    return 3'((lsu_bytes(size) + mem_bytes - 1) / mem_bytes);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Combinational load extender. Takes the assembled little-endian
//               load bytes and produces the XLEN result, zero- or
//               sign-extended from the access size. Used by both the RAM
//               path and the data-cache hit path.
// Ports       : raw_i    - assembled bytes, byte 0 in bits [7:0]
//               size_i   - access size (LSU_SZ_*)
//               signed_i - 1 = sign-extend from bit 8*bytes-1
//               data_o   - extended result
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw_i,
  input  logic [1:0]      size_i,
  input  logic            signed_i,
  output logic [XLEN-1:0] data_o
);

  always_comb begin
    data_o = raw_i;
    case (size_i)
      LSU_SZ_B: data_o = {{(XLEN-8){signed_i & raw_i[7]}}, raw_i[7:0]};
      LSU_SZ_H: data_o = {{(XLEN-16){signed_i & raw_i[15]}}, raw_i[15:0]};
      default:  data_o = raw_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/stage_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : stage_mem_lsu
// Description : MEM-stage load/store unit. Splits byte/half/word accesses into
//               MEM_BYTES-wide RAM beats issued back-to-back, assembles and
//               extends load data, and returns one registered response per
//               request. All outputs are registered.
// Config      : define LSU_DCACHE_EN to enable the data-cache port (hit
//               bypass, word fill/update, byte/half invalidate). Without it
//               all dcache_* outputs are 0 and dcache inputs are ignored.
// Ports       : clk/rst          - clock, synchronous active-high reset
//               req_*            - request handshake and payload
//               resp_valid_o/    - one-cycle completion pulse and load data
//               resp_data_o
//               busy_o           - stall indication to pipeline control
//               mem_*            - RAM beat port (read data one cycle later)
//               dcache_*         - optional data-cache lookup/update port
// Revision    : 1.0 - initial release
// ============================================================================
module stage_mem_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_store_i,
  input  logic [1:0]             req_size_i,
  input  logic                   req_signed_i,
  input  logic [ADDR_W-1:0]      req_addr_i,
  input  logic [XLEN-1:0]        req_wdata_i,
  output logic                   resp_valid_o,
  output logic [XLEN-1:0]        resp_data_o,
  output logic                   busy_o,
  output logic [ADDR_W-1:0]      mem_a_o,
  output logic                   mem_wr_o,
  output logic [MEM_BYTES-1:0]   mem_wmask_o,
  output logic [8*MEM_BYTES-1:0] mem_dout_o,
  input  logic [8*MEM_BYTES-1:0] mem_din_i,
  output logic [ADDR_W-1:0]      dcache_raddr_o,
  input  logic                   dcache_hit_i,
  input  logic [XLEN-1:0]        dcache_data_i,
  output logic                   dcache_we_o,
  output logic [ADDR_W-1:0]      dcache_waddr_o,
  output logic [XLEN-1:0]        dcache_wdata_o,
  output logic                   dcache_inv_o
);

  localparam int LANES = XLEN / (8 * MEM_BYTES);

  lsu_state_e             state_q;
  logic                   store_q, signed_q;
  logic [1:0]             size_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [XLEN-1:0]        wdata_q;
  logic [2:0]             beat_q, nbeats_q;
  logic [1:0]             cap_q;
  logic                   mem_ld_q;   // the beat on the bus this cycle is a load
  logic                   din_vld_q;  // mem_din_i carries data for lane cap_q
  logic [XLEN-1:0]        asm_q, asm_d;
  logic                   req_ready_q, resp_valid_q, busy_q;
  logic [XLEN-1:0]        resp_data_q;
  logic [ADDR_W-1:0]      mem_a_q;
  logic                   mem_wr_q;
  logic [MEM_BYTES-1:0]   mem_wmask_q;
  logic [8*MEM_BYTES-1:0] mem_dout_q;

  // Next beat: beat 0 comes straight from the request in IDLE, later beats
  // from the latched request.
  logic [1:0]             req_size_n;
  logic [ADDR_W-1:0]      nb_base, nb_addr;
  logic [XLEN-1:0]        nb_wdata;
  logic [1:0]             nb_size, nb_lane;
  logic [2:0]             nb_k;
  logic [MEM_BYTES-1:0]   nb_mask;
  logic [8*MEM_BYTES-1:0] nb_dout;

  assign req_size_n = (req_size_i == 2'd3) ? LSU_SZ_W : req_size_i;

  always_comb begin
    if (state_q == IDLE) begin
      nb_base  = req_addr_i;
      nb_wdata = req_wdata_i;
      nb_size  = req_size_n;
      nb_k     = 3'd0;
    end else begin
      nb_base  = addr_q;
      nb_wdata = wdata_q;
      nb_size  = size_q;
      nb_k     = beat_q + 3'd1;
    end
    nb_addr = nb_base + ADDR_W'(int'(nb_k) * MEM_BYTES);
    nb_mask = '0;
    nb_dout = '0;
    nb_lane = '0;
    // Only bytes still inside the access are enabled; others drive 0.
    for (int j = 0; j < MEM_BYTES; j++) begin
      nb_lane = 2'((int'(nb_k) * MEM_BYTES + j) & 3);
      if (int'(nb_k) * MEM_BYTES + j < lsu_bytes(nb_size)) begin
        nb_mask[j]       = 1'b1;
        nb_dout[8*j +: 8] = nb_wdata[{nb_lane, 3'b000} +: 8];
      end
    end
  end

  // Load assembly including the beat arriving this cycle, so the response
  // can be registered at the end of DRAIN without an extra cycle.
  always_comb begin
    asm_d = asm_q;
    if (din_vld_q) begin
      for (int k = 0; k < LANES; k++) begin
        if (cap_q == 2'(k)) asm_d[k*8*MEM_BYTES +: 8*MEM_BYTES] = mem_din_i;
      end
    end
  end

  logic [XLEN-1:0] align_raw, align_out;

`ifdef LSU_DCACHE_EN
  logic              lookup_q;
  logic [ADDR_W-1:0] dc_raddr_q, dc_waddr_q;
  logic              dc_we_q, dc_inv_q;
  logic [XLEN-1:0]   dc_wdata_q;
  logic              dc_hit;

  // A hit only counts in the cycle the lookup address is presented.
  assign dc_hit    = lookup_q & dcache_hit_i;
  assign align_raw = dc_hit ? dcache_data_i : asm_d;

  assign dcache_raddr_o = dc_raddr_q;
  assign dcache_we_o    = dc_we_q;
  assign dcache_waddr_o = dc_waddr_q;
  assign dcache_wdata_o = dc_wdata_q;
  assign dcache_inv_o   = dc_inv_q;
`else
  logic unused_dcache;
  assign unused_dcache  = ^{dcache_hit_i, dcache_data_i};
  assign align_raw      = asm_d;
  assign dcache_raddr_o = '0;
  assign dcache_we_o    = 1'b0;
  assign dcache_waddr_o = '0;
  assign dcache_wdata_o = '0;
  assign dcache_inv_o   = 1'b0;
`endif

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .raw_i    (align_raw),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (align_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= LSU_SZ_B;
      addr_q       <= '0;
      wdata_q      <= '0;
      beat_q       <= '0;
      nbeats_q     <= '0;
      cap_q        <= '0;
      mem_ld_q     <= 1'b0;
      din_vld_q    <= 1'b0;
      asm_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
      mem_a_q      <= '0;
      mem_wr_q     <= 1'b0;
      mem_wmask_q  <= '0;
      mem_dout_q   <= '0;
`ifdef LSU_DCACHE_EN
      lookup_q     <= 1'b0;
      dc_raddr_q   <= '0;
      dc_we_q      <= 1'b0;
      dc_waddr_q   <= '0;
      dc_wdata_q   <= '0;
      dc_inv_q     <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      din_vld_q    <= mem_ld_q;
      asm_q        <= asm_d;
      if (din_vld_q) cap_q <= cap_q + 2'd1;
`ifdef LSU_DCACHE_EN
      lookup_q     <= 1'b0;
      dc_raddr_q   <= '0;
      dc_we_q      <= 1'b0;
      dc_inv_q     <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            state_q     <= ISSUE;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            store_q     <= req_store_i;
            size_q      <= req_size_n;
            signed_q    <= req_signed_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            nbeats_q    <= lsu_beats(req_size_n, MEM_BYTES);
            beat_q      <= '0;
            cap_q       <= '0;
            mem_a_q     <= nb_addr;
            mem_wr_q    <= req_store_i;
            mem_wmask_q <= req_store_i ? nb_mask : '0;
            mem_dout_q  <= req_store_i ? nb_dout : '0;
            mem_ld_q    <= ~req_store_i;
`ifdef LSU_DCACHE_EN
            lookup_q    <= ~req_store_i;
            dc_raddr_q  <= req_store_i ? '0 : req_addr_i;
`endif
          end
        end
        ISSUE: begin
          if (beat_q + 3'd1 < nbeats_q) begin
            beat_q      <= beat_q + 3'd1;
            mem_a_q     <= nb_addr;
            mem_wr_q    <= store_q;
            mem_wmask_q <= store_q ? nb_mask : '0;
            mem_dout_q  <= store_q ? nb_dout : '0;
            mem_ld_q    <= ~store_q;
          end else begin
            mem_a_q     <= '0;
            mem_wr_q    <= 1'b0;
            mem_wmask_q <= '0;
            mem_dout_q  <= '0;
            mem_ld_q    <= 1'b0;
            if (store_q) begin
              state_q      <= IDLE;
              req_ready_q  <= 1'b1;
              busy_q       <= 1'b0;
              resp_valid_q <= 1'b1;
              resp_data_q  <= '0;
`ifdef LSU_DCACHE_EN
              dc_waddr_q   <= addr_q;
              dc_wdata_q   <= wdata_q;
              dc_we_q      <= (size_q == LSU_SZ_W);
              dc_inv_q     <= (size_q != LSU_SZ_W);
`endif
            end else begin
              state_q <= DRAIN;
            end
          end
`ifdef LSU_DCACHE_EN
          // Hit: drop the remaining beats and ignore the in-flight RAM data.
          if (dc_hit) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_data_q  <= align_out;
            mem_a_q      <= '0;
            mem_wr_q     <= 1'b0;
            mem_ld_q     <= 1'b0;
            din_vld_q    <= 1'b0;
          end
`endif
        end
        DRAIN: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_data_q  <= align_out;
`ifdef LSU_DCACHE_EN
          dc_we_q      <= (size_q == LSU_SZ_W);
          dc_waddr_q   <= addr_q;
          dc_wdata_q   <= asm_d;
`endif
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign busy_o       = busy_q;
  assign mem_a_o      = mem_a_q;
  assign mem_wr_o     = mem_wr_q;
  assign mem_wmask_o  = mem_wmask_q;
  assign mem_dout_o   = mem_dout_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_mem_lsu
// Description : Directed self-checking bench for stage_mem_lsu. Three units
//               (MEM_BYTES = 1, 2, 4) share one byte-addressed RAM model and
//               the request payload bus; each has its own valid. Cache tests
//               are active when LSU_DCACHE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_mem_lsu;

`ifdef LSU_DCACHE_EN
  localparam bit DC = 1'b1;
`else
  localparam bit DC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        st, sg;
  logic [1:0]  sz;
  logic [31:0] addr, wdata;
  logic        v1, v2, v4;
  int          errors = 0;
  int          checks = 0;

  // Unit 1 (MEM_BYTES=1)
  logic        rdy1, rv1, busy1, wr1, hit1, cwe1, cinv1;
  logic [31:0] rd1, a1, craddr1, cwaddr1, cwdata1;
  logic [0:0]  mask1;
  logic [7:0]  dout1, din1;
  logic        hit_en;
  // Unit 2 (MEM_BYTES=2)
  logic        rdy2, rv2, busy2, wr2, cwe2, cinv2;
  logic [31:0] rd2, a2, craddr2, cwaddr2, cwdata2;
  logic [1:0]  mask2;
  logic [15:0] dout2, din2;
  // Unit 4 (MEM_BYTES=4)
  logic        rdy4, rv4, busy4, wr4, cwe4, cinv4;
  logic [31:0] rd4, a4, craddr4, cwaddr4, cwdata4;
  logic [3:0]  mask4;
  logic [31:0] dout4, din4;

  // RAM preload port
  logic        pl_we;
  logic [9:0]  pl_a;
  logic [7:0]  pl_d;
  logic [7:0]  ram [0:1023];

  always #5 clk = ~clk;

  assign hit1 = hit_en && (craddr1 == 32'h40);

  stage_mem_lsu #(.MEM_BYTES(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid_i(v1), .req_ready_o(rdy1), .req_store_i(st),
    .req_size_i(sz), .req_signed_i(sg), .req_addr_i(addr), .req_wdata_i(wdata),
    .resp_valid_o(rv1), .resp_data_o(rd1), .busy_o(busy1), .mem_a_o(a1), .mem_wr_o(wr1),
    .mem_wmask_o(mask1), .mem_dout_o(dout1), .mem_din_i(din1), .dcache_raddr_o(craddr1),
    .dcache_hit_i(hit1), .dcache_data_i(32'h04030201), .dcache_we_o(cwe1),
    .dcache_waddr_o(cwaddr1), .dcache_wdata_o(cwdata1), .dcache_inv_o(cinv1));

  stage_mem_lsu #(.MEM_BYTES(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid_i(v2), .req_ready_o(rdy2), .req_store_i(st),
    .req_size_i(sz), .req_signed_i(sg), .req_addr_i(addr), .req_wdata_i(wdata),
    .resp_valid_o(rv2), .resp_data_o(rd2), .busy_o(busy2), .mem_a_o(a2), .mem_wr_o(wr2),
    .mem_wmask_o(mask2), .mem_dout_o(dout2), .mem_din_i(din2), .dcache_raddr_o(craddr2),
    .dcache_hit_i(1'b0), .dcache_data_i(32'h0), .dcache_we_o(cwe2),
    .dcache_waddr_o(cwaddr2), .dcache_wdata_o(cwdata2), .dcache_inv_o(cinv2));

  stage_mem_lsu #(.MEM_BYTES(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid_i(v4), .req_ready_o(rdy4), .req_store_i(st),
    .req_size_i(sz), .req_signed_i(sg), .req_addr_i(addr), .req_wdata_i(wdata),
    .resp_valid_o(rv4), .resp_data_o(rd4), .busy_o(busy4), .mem_a_o(a4), .mem_wr_o(wr4),
    .mem_wmask_o(mask4), .mem_dout_o(dout4), .mem_din_i(din4), .dcache_raddr_o(craddr4),
    .dcache_hit_i(1'b0), .dcache_data_i(32'h0), .dcache_we_o(cwe4),
    .dcache_waddr_o(cwaddr4), .dcache_wdata_o(cwdata4), .dcache_inv_o(cinv4));

  // Shared RAM: masked writes, read data one cycle after the address.
  always @(posedge clk) begin
    if (pl_we) ram[pl_a] <= pl_d;
    if (wr1 && mask1[0]) ram[a1[9:0]] <= dout1;
    if (wr2) for (int j = 0; j < 2; j++) if (mask2[j]) ram[a2[9:0] + 10'(j)] <= dout2[8*j +: 8];
    if (wr4) for (int j = 0; j < 4; j++) if (mask4[j]) ram[a4[9:0] + 10'(j)] <= dout4[8*j +: 8];
    din1 <= ram[a1[9:0]];
    din2 <= {ram[a2[9:0] + 10'd1], ram[a2[9:0]]};
    din4 <= {ram[a4[9:0] + 10'd3], ram[a4[9:0] + 10'd2], ram[a4[9:0] + 10'd1], ram[a4[9:0]]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    step();
    pl_we = 1'b0;
  endtask

  // Present a request to one unit in cycle 0; returns in cycle 1.
  task automatic issue(input int u, input logic s, input logic [1:0] z, input logic g,
                       input logic [31:0] ad, input logic [31:0] d);
    st = s; sz = z; sg = g; addr = ad; wdata = d;
    v1 = (u == 1); v2 = (u == 2); v4 = (u == 4);
    step();
    v1 = 1'b0; v2 = 1'b0; v4 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; st = 1'b0; sg = 1'b0; sz = 2'd0; addr = '0; wdata = '0;
    v1 = 1'b0; v2 = 1'b0; v4 = 1'b0; hit_en = 1'b0;
    pl_we = 1'b0; pl_a = '0; pl_d = '0;
    step(); step();
    preload(10'h100, 8'h11); preload(10'h101, 8'h22);
    preload(10'h102, 8'h33); preload(10'h103, 8'h44);
    preload(10'h007, 8'h80);
    preload(10'h040, 8'h01); preload(10'h041, 8'h02);
    preload(10'h042, 8'h03); preload(10'h043, 8'h04);

    // Reset state
    chk("rst_ready1", rdy1, 1); chk("rst_ready4", rdy4, 1);
    chk("rst_rv1", rv1, 0); chk("rst_wr1", wr1, 0);
    chk("rst_a1", a1, 0); chk("rst_busy1", busy1, 0);
    rst = 1'b0;
    step();

    // LW 0x100 on byte bus: four beats, response in cycle 6
    issue(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    chk("lw_a_c1", a1, 32'h100); chk("lw_busy_c1", busy1, 1); chk("lw_ready_c1", rdy1, 0);
    chk("lw_wr_c1", wr1, 0); chk("lw_craddr", craddr1, DC ? 32'h100 : 32'h0);
    step(); chk("lw_a_c2", a1, 32'h101);
    step(); chk("lw_a_c3", a1, 32'h102);
    step(); chk("lw_a_c4", a1, 32'h103);
    step(); chk("lw_a_c5", a1, 32'h0); chk("lw_rv_c5", rv1, 0);
    step(); chk("lw_rv_c6", rv1, 1); chk("lw_data", rd1, 32'h44332211);
    chk("lw_ready_c6", rdy1, 1); chk("lw_fill_we", cwe1, DC);
    step(); chk("lw_rv_c7", rv1, 0);

    // LB signed / LBU at 0x7
    issue(1, 1'b0, 2'd0, 1'b1, 32'h7, 32'h0);
    chk("lb_a_c1", a1, 32'h7);
    step(); step(); chk("lb_rv_c3", rv1, 1); chk("lb_data", rd1, 32'hFFFFFF80);
    issue(1, 1'b0, 2'd0, 1'b0, 32'h7, 32'h0);
    step(); step(); chk("lbu_rv_c3", rv1, 1); chk("lbu_data", rd1, 32'h00000080);

    // SW on half-word bus, misaligned
    issue(2, 1'b1, 2'd2, 1'b0, 32'h202, 32'hDEADBEEF);
    chk("sw_a0", a2, 32'h202); chk("sw_wr0", wr2, 1); chk("sw_dout0", dout2, 32'hBEEF); chk("sw_mask0", mask2, 2'b11);
    step(); chk("sw_a1", a2, 32'h204); chk("sw_dout1", dout2, 32'hDEAD); chk("sw_mask1", mask2, 2'b11);
    step(); chk("sw_rv_c3", rv2, 1); chk("sw_rdata", rd2, 0); chk("sw_wr_c3", wr2, 0); chk("sw_a_c3", a2, 0);
    // LH signed at odd address straddling the stored word
    issue(2, 1'b0, 2'd1, 1'b1, 32'h203, 32'h0);
    chk("lh_a", a2, 32'h203);
    step(); step(); chk("lh_rv_c3", rv2, 1); chk("lh_data", rd2, 32'hFFFFADBE);

    // SH on word bus, then LHU held on valid and accepted in the response cycle
    st = 1'b1; sz = 2'd1; sg = 1'b0; addr = 32'h10; wdata = 32'h1234ABCD; v4 = 1'b1;
    step();
    st = 1'b0;
    chk("sh_a", a4, 32'h10); chk("sh_wr", wr4, 1); chk("sh_mask", mask4, 4'b0011);
    chk("sh_dout", {16'h0, dout4[15:0]}, 32'hABCD); chk("sh_ready_c1", rdy4, 0);
    step(); chk("sh_rv_c2", rv4, 1); chk("sh_ready_c2", rdy4, 1); chk("sh_wr_c2", wr4, 0);
    step(); v4 = 1'b0;
    chk("lhu_a_c3", a4, 32'h10); chk("lhu_busy_c3", busy4, 1); chk("lhu_rv_c3", rv4, 0);
    step(); chk("lhu_rv_c4", rv4, 0);
    step(); chk("lhu_rv_c5", rv4, 1); chk("lhu_data", rd4, 32'h0000ABCD);

    // SB on word bus: only byte 0 enabled
    issue(4, 1'b1, 2'd0, 1'b0, 32'h21, 32'h00000055);
    chk("sb_mask", mask4, 4'b0001); chk("sb_dout", {24'h0, dout4[7:0]}, 32'h55);
    step(); chk("sb_rv_c2", rv4, 1);

    // Size 3 behaves as word
    issue(4, 1'b0, 2'd3, 1'b1, 32'h100, 32'h0);
    step(); step(); chk("sz3_rv", rv4, 1); chk("sz3_data", rd4, 32'h44332211);

    // Reset mid-store: no response, bus quiet, ready restored
    issue(1, 1'b1, 2'd2, 1'b0, 32'h300, 32'h01020304);
    chk("abort_wr_c1", wr1, 1); chk("abort_dout_c1", dout1, 32'h04);
    step(); chk("abort_a_c2", a1, 32'h301); rst = 1'b1;
    step(); chk("abort_wr_c3", wr1, 0); chk("abort_ready_c3", rdy1, 1);
    chk("abort_rv_c3", rv1, 0); chk("abort_busy_c3", busy1, 0);
    rst = 1'b0;
    step(); chk("abort_rv_c4", rv1, 0);
    step(); chk("abort_rv_c5", rv1, 0); chk("abort_a_c5", a1, 0);

`ifdef LSU_DCACHE_EN
    // Word-load miss fills the cache; the repeat hits and answers in cycle 2
    issue(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    chk("dc_raddr_c1", craddr1, 32'h40);
    repeat (5) step();
    chk("dc_miss_rv", rv1, 1); chk("dc_miss_data", rd1, 32'h04030201);
    chk("dc_fill_we", cwe1, 1); chk("dc_fill_addr", cwaddr1, 32'h40); chk("dc_fill_data", cwdata1, 32'h04030201);
    hit_en = 1'b1;
    issue(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    chk("dc_hit_a_c1", a1, 32'h40);
    step(); chk("dc_hit_rv_c2", rv1, 1); chk("dc_hit_data", rd1, 32'h04030201); chk("dc_hit_a_c2", a1, 0);
    step(); chk("dc_hit_a_c3", a1, 0); chk("dc_hit_rv_c3", rv1, 0);
    hit_en = 1'b0;
`else
    chk("nodc_we", cwe2, 0); chk("nodc_raddr", craddr4, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
